// File: rtl/axi_sram_slave_if.sv
// AXI3 single-beat channel bundle between the core-side bridge (master)
// and the SRAM endpoint (slave).
//   AR : arid, araddr, arlen, arsize, arvalid / arready
//   R  : rid, rdata, rresp, rlast, rvalid / rready
//   AW : awid, awaddr, awlen, awsize, awvalid / awready
//   W  : wid, wdata, wstrb, wlast, wvalid / wready
//   B  : bid, bresp, bvalid / bready
interface axi_sram_slave_if #(
  parameter int ID_WID = 4
);
  logic [ID_WID-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_WID-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_WID-1:0] awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [ID_WID-1:0] wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_WID-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave serving reads and writes from one single-port
// synchronous SRAM. Independent read FSM and write buffers share the RAM
// port through an alternating-priority arbiter.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   axi          : AXI3 slave channels (AR/R/AW/W/B)
//   ram_en       : RAM access enable
//   ram_we       : per-byte write enable, 0 for a read
//   ram_addr     : RAM word address (byte address [RAM_AW+1:2])
//   ram_wdata    : RAM write data
//   ram_rdata    : RAM read data, valid the cycle after a read access
module axi_sram_slave #(
  parameter int ID_WID = 4,
  parameter int RAM_AW = 16
) (
  input  logic              aclk,
  input  logic              areset,
  axi_sram_slave_if.slave   axi,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  logic [1:0]        r_state;
  logic [ID_WID-1:0] ar_id_q;
  logic [RAM_AW-1:0] ar_addr_q;
  logic [31:0]       rdata_q;

  logic              aw_full;
  logic              w_full;
  logic [ID_WID-1:0] aw_id_q;
  logic [RAM_AW-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [ID_WID-1:0] bid_q;

  logic              prio_rd;
  logic              rd_req;
  logic              wr_req;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              arready_int;
  logic              awready_int;
  logic              wready_int;

  // Handshake outputs are forced low during the reset cycle itself,
  // before the synchronous reset has cleared the state.
  assign arready_int = (r_state == R_IDLE) & ~areset;
  assign awready_int = ~aw_full & ~bvalid_q & ~areset;
  assign wready_int  = ~w_full & ~bvalid_q & ~areset;

  assign rd_req = (r_state == R_REQ) & ~areset;
  assign wr_req = aw_full & w_full & ~areset;
  assign rd_gnt = rd_req & (~wr_req | prio_rd);
  assign wr_gnt = wr_req & (~rd_req | ~prio_rd);

  assign ram_en    = rd_gnt | wr_gnt;
  assign ram_we    = wr_gnt ? w_strb_q : '0;
  assign ram_addr  = wr_gnt ? aw_addr_q : ar_addr_q;
  assign ram_wdata = wr_gnt ? w_data_q : '0;

  assign axi.arready = arready_int;
  assign axi.rid     = ar_id_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = '0;
  assign axi.rlast   = 1'b1;
  assign axi.rvalid  = (r_state == R_RESP) & ~areset;
  assign axi.awready = awready_int;
  assign axi.wready  = wready_int;
  assign axi.bid     = bid_q;
  assign axi.bresp   = '0;
  assign axi.bvalid  = bvalid_q & ~areset;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (axi.arvalid) begin
          ar_id_q   <= axi.arid;
          ar_addr_q <= axi.araddr[RAM_AW+1:2];
          r_state   <= R_REQ;
        end
        R_REQ:  if (rd_gnt) r_state <= R_DATA;
        R_DATA: begin
          rdata_q <= ram_rdata;
          r_state <= R_RESP;
        end
        R_RESP: if (axi.rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      prio_rd   <= 1'b1;
    end else begin
      if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
      if (wr_gnt) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bid_q    <= aw_id_q;
      end else begin
        if (axi.awvalid && awready_int) begin
          aw_full   <= 1'b1;
          aw_id_q   <= axi.awid;
          aw_addr_q <= axi.awaddr[RAM_AW+1:2];
        end
        if (axi.wvalid && wready_int) begin
          w_full   <= 1'b1;
          w_data_q <= axi.wdata;
          w_strb_q <= axi.wstrb;
        end
      end
      // Priority moves to the loser only when both sides asked together.
      if (rd_req && wr_req) prio_rd <= ~prio_rd;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{axi.arlen, axi.arsize, axi.awlen, axi.awsize,
                           axi.wid, axi.wlast,
                           axi.araddr[31:RAM_AW+2], axi.araddr[1:0],
                           axi.awaddr[31:RAM_AW+2], axi.awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  logic        aclk = 1'b0;
  logic        areset;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:255];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  axi_sram_slave_if #(.ID_WID(4)) bus ();

  axi_sram_slave #(.ID_WID(4), .RAM_AW(16)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .axi       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 aclk = ~aclk;

  // Behavioural single-port synchronous SRAM.
  always @(posedge aclk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input logic [31:0] data, input logic [3:0] strb);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id;
    bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
    check("wr_awready", bus.awready, 1);
    check("wr_wready", bus.wready, 1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_we", ram_we, strb);
    check("wr_ram_addr", ram_addr, (addr >> 2) & 32'hFFFF);
    check("wr_ram_wdata", ram_wdata, data);
    step();
    check("wr_bvalid", bus.bvalid, 1);
    check("wr_bid", bus.bid, id);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("wr_bvalid_clr", bus.bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input logic [31:0] exp, input int unsigned hold);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id;
    check("rd_arready", bus.arready, 1);
    step();
    bus.arvalid = 1'b0;
    check("rd_ram_en", ram_en, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, (addr >> 2) & 32'hFFFF);
    check("rd_arready_busy", bus.arready, 0);
    step();
    check("rd_rvalid_early", bus.rvalid, 0);
    step();
    check("rd_rvalid", bus.rvalid, 1);
    check("rd_rdata", bus.rdata, exp);
    check("rd_rid", bus.rid, id);
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      check("hold_rvalid", bus.rvalid, 1);
      check("hold_rdata", bus.rdata, exp);
      check("hold_rid", bus.rid, id);
      check("hold_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    check("rd_rvalid_clr", bus.rvalid, 0);
    check("rd_arready_idle", bus.arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_rdata   = 32'h0;
    areset      = 1'b1;
    bus.arid    = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid    = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2;
    bus.awvalid = 1'b0;
    bus.wid     = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b1;
    bus.wvalid  = 1'b0; bus.bready = 1'b0;

    // Reset
    step(); step();
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_ram_en", ram_en, 0);
    areset = 1'b0;
    step();
    check("post_arready", bus.arready, 1);
    check("post_awready", bus.awready, 1);
    check("post_wready", bus.wready, 1);
    check("post_rdata", bus.rdata, 0);
    check("post_rid", bus.rid, 0);
    check("post_bid", bus.bid, 0);
    check("post_rresp", bus.rresp, 0);
    check("post_rlast", bus.rlast, 1);

    // 1: write then read back
    do_write(32'h1C, 4'd1, 32'h12345678, 4'hF);
    do_read(32'h1C, 4'd0, 32'h12345678, 0);

    // 2: W three cycles ahead of AW, partial strobes
    bus.wvalid = 1'b1; bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101;
    step();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_low", bus.wready, 0);
      check("t2_no_ram", ram_en, 0);
      check("t2_awready", bus.awready, 1);
      if (i < 2) step();
    end
    bus.awvalid = 1'b1; bus.awaddr = 32'h20; bus.awid = 4'd4;
    step();
    bus.awvalid = 1'b0;
    check("t2_ram_en", ram_en, 1);
    check("t2_ram_we", ram_we, 4'b0101);
    check("t2_ram_addr", ram_addr, 16'h8);
    step();
    check("t2_bvalid", bus.bvalid, 1);
    check("t2_bid", bus.bid, 4);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    do_read(32'h20, 4'd0, 32'h00BB00DD, 0);

    // 3: two back-to-back read/write conflicts
    areset = 1'b1; step(); areset = 1'b0; step();
    bus.arvalid = 1'b1; bus.araddr = 32'h1C; bus.arid = 4'd1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h40; bus.awid = 4'd0;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h11112222; bus.wstrb = 4'hF;
    step();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("c1_ram_en", ram_en, 1);
    check("c1_rd_first", ram_we, 0);
    check("c1_rd_addr", ram_addr, 16'h7);
    step();
    check("c1_wr_second", ram_we, 4'hF);
    check("c1_wr_addr", ram_addr, 16'h10);
    step();
    check("c1_rvalid", bus.rvalid, 1);
    check("c1_rdata", bus.rdata, 32'h12345678);
    check("c1_rid", bus.rid, 1);
    check("c1_bvalid", bus.bvalid, 1);
    check("c1_bid", bus.bid, 0);
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("c1_rvalid_clr", bus.rvalid, 0);
    check("c1_bvalid_clr", bus.bvalid, 0);
    bus.arvalid = 1'b1; bus.araddr = 32'h40; bus.arid = 4'd1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h44; bus.awid = 4'd2;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h33334444; bus.wstrb = 4'hF;
    step();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("c2_wr_first", ram_we, 4'hF);
    check("c2_wr_addr", ram_addr, 16'h11);
    step();
    check("c2_ram_en", ram_en, 1);
    check("c2_rd_second", ram_we, 0);
    check("c2_rd_addr", ram_addr, 16'h10);
    check("c2_bvalid", bus.bvalid, 1);
    check("c2_bid", bus.bid, 2);
    step();
    check("c2_rvalid_early", bus.rvalid, 0);
    step();
    check("c2_rvalid", bus.rvalid, 1);
    check("c2_rdata", bus.rdata, 32'h11112222);
    check("c2_rid", bus.rid, 1);
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("c2_rvalid_clr", bus.rvalid, 0);
    check("c2_bvalid_clr", bus.bvalid, 0);

    // 4: rready held low for 5 cycles
    do_read(32'h20, 4'd1, 32'h00BB00DD, 5);

    // 5: bready held low blocks further writes
    bus.awvalid = 1'b1; bus.awaddr = 32'h24; bus.awid = 4'd3;
    bus.wvalid  = 1'b1; bus.wdata  = 32'hCAFEF00D; bus.wstrb = 4'hF;
    step();
    bus.awaddr = 32'h28; bus.awid = 4'd5; bus.wdata = 32'h0BADBEEF;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t5_ram_addr", ram_addr, 16'h9);
    step();
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_bvalid_hold", bus.bvalid, 1);
      check("t5_awready_low", bus.awready, 0);
      check("t5_wready_low", bus.wready, 0);
      step();
    end
    bus.bready = 1'b1;
    check("t5_bid", bus.bid, 3);
    step();
    bus.bready = 1'b0;
    check("t5_bvalid_clr", bus.bvalid, 0);
    check("t5_awready_back", bus.awready, 1);
    check("t5_wready_back", bus.wready, 1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t5_ram_we2", ram_we, 4'hF);
    check("t5_ram_addr2", ram_addr, 16'hA);
    check("t5_ram_wdata2", ram_wdata, 32'h0BADBEEF);
    step();
    check("t5_bvalid2", bus.bvalid, 1);
    check("t5_bid2", bus.bid, 5);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    do_read(32'h28, 4'd0, 32'h0BADBEEF, 0);
    do_read(32'h24, 4'd0, 32'hCAFEF00D, 0);

    // 6: reset during R_DATA with an AW buffered
    bus.arvalid = 1'b1; bus.araddr = 32'h1C; bus.arid = 4'd1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h30; bus.awid = 4'd6;
    step();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    check("t6_ram_en", ram_en, 1);
    check("t6_awready_full", bus.awready, 0);
    step();
    areset = 1'b1;
    step();
    check("t6_rst_arready", bus.arready, 0);
    check("t6_rst_awready", bus.awready, 0);
    check("t6_rst_wready", bus.wready, 0);
    areset = 1'b0;
    step();
    check("t6_arready", bus.arready, 1);
    check("t6_awready", bus.awready, 1);
    check("t6_wready", bus.wready, 1);
    bus.wvalid = 1'b1; bus.wdata = 32'h55555555; bus.wstrb = 4'hF;
    step();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_rvalid", bus.rvalid, 0);
      check("t6_no_bvalid", bus.bvalid, 0);
      check("t6_no_ram", ram_en, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
